// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV M-extension unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_S_IDLE = 2'd0,
      MD_S_MUL  = 2'd1,
      MD_S_DIV  = 2'd2,
      MD_S_DONE = 2'd3
   } md_state_t;

   function automatic logic md_is_div(input muldiv_op_t op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   function automatic logic md_is_rem(input muldiv_op_t op);
      return op inside {MD_REM, MD_REMU};
   endfunction

   function automatic logic md_is_signed1(input muldiv_op_t op);
      return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic md_is_signed2(input muldiv_op_t op);
      return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring magnitude divider retiring DIV_RADIX quotient bits per step.
// quotient/remainder include the step being retired this cycle, so the caller can latch them on the last step.
module muldiv_div_core #(
   parameter int XLEN      = 32,
   parameter int DIV_RADIX = 1,
   parameter int CW        = $clog2(XLEN / DIV_RADIX + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [CW-1:0]   step_cnt,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN:0]   rem_q, r;
   logic [XLEN-1:0] quo_q, dvsr_q, q;

   always_comb begin
      r = rem_q;
      q = quo_q;
      for (int i = 0; i < DIV_RADIX; i++) begin
         r = {r[XLEN-1:0], q[XLEN-1]};
         q = {q[XLEN-2:0], 1'b0};
         if (r >= {1'b0, dvsr_q}) begin
            r    = r - {1'b0, dvsr_q};
            q[0] = 1'b1;
         end
      end
      quotient  = q;
      remainder = r[XLEN-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         step_cnt <= '0;
      end else if (start) begin
         rem_q    <= '0;
         quo_q    <= dividend;
         dvsr_q   <= divisor;
         step_cnt <= '0;
      end else if (step) begin
         rem_q    <= r;
         quo_q    <= q;
         step_cnt <= step_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/DIV unit for the EX stage with divide fast paths, flush kill and a one-entry result cache.
// Handshake: a request moves on an edge with req_valid && req_ready; a response moves on an edge with resp_valid && resp_ready.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MUL_RADIX = 2,
   parameter int DIV_RADIX = 1,
   parameter int TAG_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [XLEN-1:0]  req_op1,
   input  logic [XLEN-1:0]  req_op2,
   input  logic             kill,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [TAG_W-1:0] resp_tag,
   output logic [XLEN-1:0]  resp_data,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int MUL_STEPS = XLEN / MUL_RADIX;
   localparam int DIV_STEPS = XLEN / DIV_RADIX;
   localparam int MCW       = $clog2(MUL_STEPS + 1);
   localparam int DCW       = $clog2(DIV_STEPS + 1);
   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_t         state, state_nxt;
   muldiv_op_t        in_op, op_q, cache_op;
   logic              accept, in_s1, in_s2, div_zero, div_ovf, cache_hit, fast, finish;
   logic [XLEN-1:0]   in_mag1, in_mag2, fast_res, op1_q, op2_q;
   logic              s1_q, s2_q, cache_vld;
   logic [TAG_W-1:0]  tag_q, cache_tag;
   logic [XLEN-1:0]   cache_op1, cache_op2, cache_res;
   logic [2*XLEN-1:0] acc, acc_nxt, mcand, prod;
   logic [XLEN-1:0]   mplier, mul_res, div_res, core_res, quo, rem;
   logic [MCW-1:0]    mul_cnt;
   logic [DCW-1:0]    div_cnt;

   assign in_op   = muldiv_op_t'(req_op);
   assign accept  = req_valid && req_ready;
   assign in_s1   = md_is_signed1(in_op) && req_op1[XLEN-1];
   assign in_s2   = md_is_signed2(in_op) && req_op2[XLEN-1];
   assign in_mag1 = in_s1 ? -req_op1 : req_op1;
   assign in_mag2 = in_s2 ? -req_op2 : req_op2;

   assign div_zero  = md_is_div(in_op) && (req_op2 == '0);
   assign div_ovf   = (in_op == MD_DIV || in_op == MD_REM) && (req_op1 == XMIN) && (req_op2 == '1);
   assign cache_hit = cache_vld && cache_tag == req_tag && cache_op == in_op &&
                      cache_op1 == req_op1 && cache_op2 == req_op2;
   assign fast      = div_zero || div_ovf || cache_hit;

   always_comb begin
      fast_res = '0;
      if (cache_hit)     fast_res = cache_res;
      else if (div_zero) fast_res = md_is_rem(in_op) ? req_op1 : '1;
      else if (div_ovf)  fast_res = md_is_rem(in_op) ? '0 : XMIN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MD_S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         MD_S_IDLE: if (accept) state_nxt = fast ? MD_S_DONE : (md_is_div(in_op) ? MD_S_DIV : MD_S_MUL);
         MD_S_MUL:  if (mul_cnt == MCW'(MUL_STEPS - 1)) state_nxt = MD_S_DONE;
         MD_S_DIV:  if (div_cnt == DCW'(DIV_STEPS - 1)) state_nxt = MD_S_DONE;
         MD_S_DONE: if (resp_ready) state_nxt = MD_S_IDLE;
         default:   state_nxt = MD_S_IDLE;
      endcase
      if (kill) state_nxt = MD_S_IDLE;
   end

   always_comb begin
      req_ready  = (state == MD_S_IDLE) && !kill;
      resp_valid = (state == MD_S_DONE);
      busy       = (state != MD_S_IDLE);
      state_dbg  = state;
   end

   // Each multiply step folds MUL_RADIX shifted partial products into the accumulator.
   always_comb begin
      acc_nxt = acc;
      for (int j = 0; j < MUL_RADIX; j++)
         if (mplier[j]) acc_nxt = acc_nxt + (mcand << j);
   end

   assign prod     = (s1_q ^ s2_q) ? -acc_nxt : acc_nxt;
   assign mul_res  = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   assign div_res  = md_is_rem(op_q) ? (s1_q ? -rem : rem) : ((s1_q ^ s2_q) ? -quo : quo);
   assign core_res = (state == MD_S_MUL) ? mul_res : div_res;
   assign finish   = (state == MD_S_MUL || state == MD_S_DIV) && state_nxt == MD_S_DONE;

   muldiv_div_core #(.XLEN(XLEN), .DIV_RADIX(DIV_RADIX), .CW(DCW)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept && !fast && md_is_div(in_op)),
      .step      (state == MD_S_DIV),
      .dividend  (in_mag1),
      .divisor   (in_mag2),
      .step_cnt  (div_cnt),
      .quotient  (quo),
      .remainder (rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= MD_MUL; tag_q <= '0; op1_q <= '0; op2_q <= '0; s1_q <= 1'b0; s2_q <= 1'b0;
         acc <= '0; mcand <= '0; mplier <= '0; mul_cnt <= '0;
         resp_data <= '0; resp_tag <= '0;
         cache_vld <= 1'b0; cache_tag <= '0; cache_op <= MD_MUL;
         cache_op1 <= '0; cache_op2 <= '0; cache_res <= '0;
      end else begin
         if (accept) begin
            op_q    <= in_op;
            tag_q   <= req_tag;
            op1_q   <= req_op1;
            op2_q   <= req_op2;
            s1_q    <= in_s1;
            s2_q    <= in_s2;
            acc     <= '0;
            mcand   <= {{XLEN{1'b0}}, in_mag1};
            mplier  <= in_mag2;
            mul_cnt <= '0;
         end
         if (state == MD_S_MUL) begin
            acc     <= acc_nxt;
            mcand   <= mcand << MUL_RADIX;
            mplier  <= mplier >> MUL_RADIX;
            mul_cnt <= mul_cnt + 1'b1;
         end
         if (accept && fast) begin
            resp_data <= fast_res;
            resp_tag  <= req_tag;
            cache_vld <= 1'b1;
            cache_tag <= req_tag;
            cache_op  <= in_op;
            cache_op1 <= req_op1;
            cache_op2 <= req_op2;
            cache_res <= fast_res;
         end
         // A killed operation never reaches finish, so it cannot pollute the cache.
         if (finish) begin
            resp_data <= core_res;
            resp_tag  <= tag_q;
            cache_vld <= 1'b1;
            cache_tag <= tag_q;
            cache_op  <= op_q;
            cache_op1 <= op1_q;
            cache_op2 <= op2_q;
            cache_res <= core_res;
         end
      end
   end

endmodule
